sram_vga_arbiter: RTL

SRAM_VGA_ARBITER -- requirements
Module: sram_vga_arbiter

---
 rtl/sram_vga_arbiter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/sram_vga_arbiter.sv
// Two-port arbiter sharing one asynchronous 32-bit SRAM between VGA prefetch
// reads and host reads/writes. Grants are combinational and issued only in IDLE.
module sram_vga_arbiter #(
  parameter int ACCESS_CYC = 2,
  parameter int ADDR_W     = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vga_req,
  input  logic              vga_urgent,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_gnt,
  output logic [31:0]       vga_rdata,
  output logic              vga_rvalid,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [3:0]        host_be,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [31:0]       host_wdata,
  output logic              host_gnt,
  output logic [31:0]       host_rdata,
  output logic              host_rvalid,
  output logic              host_wack,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_data_o,
  input  logic [31:0]       ram_data_i,
  output logic              ram_data_oe,
  output logic [3:0]        ram_be_n,
  output logic              ram_ce_n,
  output logic              ram_oe_n,
  output logic              ram_we_n,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD} state_t;

  localparam logic [2:0] LAST = 3'(ACCESS_CYC - 1);

  state_t     state, state_nxt;
  logic [2:0] cnt, cnt_nxt;
  logic       last_host;
  logic       own_host;
  logic [3:0] be_r;
  logic       rd_done;

  // Urgent VGA wins outright; on contention the side not served last wins.
  always_comb begin
    vga_gnt  = 1'b0;
    host_gnt = 1'b0;
    if (rst_n && state == IDLE) begin
      if (vga_req && (vga_urgent || !host_req || last_host))
        vga_gnt = 1'b1;
      else if (host_req)
        host_gnt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    case (state)
      IDLE: begin
        if (vga_gnt)
          state_nxt = RD;
        else if (host_gnt)
          state_nxt = host_we ? WR_SETUP : RD;
      end
      RD: begin
        if (cnt == LAST) state_nxt = IDLE;
        else             cnt_nxt   = cnt + 3'd1;
      end
      WR_SETUP: state_nxt = WR_PULSE;
      WR_PULSE: begin
        if (cnt == LAST) state_nxt = WR_HOLD;
        else             cnt_nxt   = cnt + 3'd1;
      end
      WR_HOLD:  state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ram_ce_n    = 1'b1;
    ram_oe_n    = 1'b1;
    ram_we_n    = 1'b1;
    ram_data_oe = 1'b0;
    ram_be_n    = '1;
    host_wack   = 1'b0;
    busy        = (state != IDLE);
    case (state)
      RD: begin
        ram_ce_n = 1'b0;
        ram_oe_n = 1'b0;
        ram_be_n = '0;
      end
      WR_SETUP: begin
        ram_ce_n    = 1'b0;
        ram_data_oe = 1'b1;
        ram_be_n    = ~be_r;
      end
      WR_PULSE: begin
        ram_ce_n    = 1'b0;
        ram_we_n    = 1'b0;
        ram_data_oe = 1'b1;
        ram_be_n    = ~be_r;
      end
      WR_HOLD: begin
        ram_ce_n    = 1'b0;
        ram_data_oe = 1'b1;
        ram_be_n    = ~be_r;
        host_wack   = 1'b1;
      end
      default: ;
    endcase
  end

  // Request fields are captured on the grant edge and held through IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_addr   <= '0;
      ram_data_o <= '0;
      be_r       <= '0;
      own_host   <= 1'b0;
      last_host  <= 1'b1;
    end else if (vga_gnt) begin
      ram_addr  <= vga_addr;
      own_host  <= 1'b0;
      last_host <= 1'b0;
    end else if (host_gnt) begin
      ram_addr   <= host_addr;
      ram_data_o <= host_wdata;
      be_r       <= host_be;
      own_host   <= 1'b1;
      last_host  <= 1'b1;
    end
  end

  assign rd_done = (state == RD) && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_rdata   <= '0;
      host_rdata  <= '0;
      vga_rvalid  <= 1'b0;
      host_rvalid <= 1'b0;
    end else begin
      vga_rvalid  <= rd_done && !own_host;
      host_rvalid <= rd_done && own_host;
      if (rd_done && own_host)  host_rdata <= ram_data_i;
      if (rd_done && !own_host) vga_rdata  <= ram_data_i;
    end
  end

endmodule
